// File: rtl/mailbox_apb_port.sv
// APB3 slave front-end for one side of the inter-hart mailbox interrupt block.
// Turns register accesses into mailbox wr/rd strobes and counts mailbox interrupt edges.
module mailbox_apb_port #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 15,
   parameter logic [7:0]  SIDE_ID = 8'h0A
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              mb_wr,
   output logic              mb_rd,
   output logic [2:0]        mb_wdata,
   input  logic [2:0]        mb_rdata,
   input  logic              mb_rvalid,
   input  logic              mp_irq
);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RESP
   } state_e;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_IRQCNT = 2'd2;
   localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [31:0] prdata_q, prdata_d;
   logic        pready_q, pready_d;
   logic        pslverr_q, pslverr_d;
   logic        mb_wr_q, mb_wr_d;
   logic        mb_rd_q, mb_rd_d;
   logic [2:0]  mb_wdata_q, mb_wdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        sticky_to_q, sticky_to_d;
   logic [15:0] irqcnt_q, irqcnt_d;
   logic        mp_irq_q;

   logic        setup;
   logic [1:0]  reg_sel;
   logic        irq_clr;
   logic        irq_rise;
   logic [31:0] status_val;
   logic        unused_inputs;

   assign setup         = psel & ~penable;
   assign reg_sel       = paddr[3:2];
   assign irq_rise      = mp_irq & ~mp_irq_q;
   assign status_val    = {16'd0, SIDE_ID, 6'd0, sticky_to_q, mp_irq_q};
   assign unused_inputs = ^{paddr[ADDR_W-1:4], paddr[1:0], pwdata[31:3]};

   always_comb begin
      state_d     = state_q;
      prdata_d    = prdata_q;
      pready_d    = 1'b0;
      pslverr_d   = 1'b0;
      mb_wr_d     = 1'b0;
      mb_rd_d     = 1'b0;
      mb_wdata_d  = mb_wdata_q;
      cnt_d       = cnt_q;
      sticky_to_d = sticky_to_q;
      irq_clr     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (setup) begin
               unique case (reg_sel)
                  OFF_CTRL: begin
                     if (pwrite) begin
                        mb_wr_d    = 1'b1;
                        mb_wdata_d = pwdata[2:0];
                        pready_d   = 1'b1;
                     end else begin
                        mb_rd_d = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = RD_WAIT;
                     end
                  end
                  OFF_STATUS: begin
                     pready_d = 1'b1;
                     if (pwrite) begin
                        pslverr_d = 1'b1;
                        prdata_d  = 32'd0;
                     end else begin
                        prdata_d = status_val;
                     end
                  end
                  OFF_IRQCNT: begin
                     pready_d = 1'b1;
                     if (pwrite) begin
                        irq_clr = 1'b1;
                     end else begin
                        prdata_d = {16'd0, irqcnt_q};
                     end
                  end
                  default: begin
                     pready_d  = 1'b1;
                     pslverr_d = 1'b1;
                     prdata_d  = 32'd0;
                  end
               endcase
            end
         end

         // The strobe cycle itself does not count toward the timeout window.
         RD_WAIT: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (mb_rvalid) begin
               prdata_d = {29'd0, mb_rdata};
               pready_d = 1'b1;
               state_d  = RESP;
            end else if (mb_rd_q) begin
               cnt_d = 8'd0;
            end else if (cnt_q == CNT_LAST) begin
               prdata_d    = 32'd0;
               sticky_to_d = 1'b1;
               pready_d    = 1'b1;
               pslverr_d   = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      irqcnt_d = irqcnt_q;
      if (irq_clr) begin
         irqcnt_d = irq_rise ? 16'd1 : 16'd0;
      end else if (irq_rise && (irqcnt_q != 16'hFFFF)) begin
         irqcnt_d = irqcnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         prdata_q    <= 32'd0;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
         mb_wr_q     <= 1'b0;
         mb_rd_q     <= 1'b0;
         mb_wdata_q  <= 3'd0;
         cnt_q       <= 8'd0;
         sticky_to_q <= 1'b0;
         irqcnt_q    <= 16'd0;
         mp_irq_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         prdata_q    <= prdata_d;
         pready_q    <= pready_d;
         pslverr_q   <= pslverr_d;
         mb_wr_q     <= mb_wr_d;
         mb_rd_q     <= mb_rd_d;
         mb_wdata_q  <= mb_wdata_d;
         cnt_q       <= cnt_d;
         sticky_to_q <= sticky_to_d;
         irqcnt_q    <= irqcnt_d;
         mp_irq_q    <= mp_irq;
      end
   end

   assign prdata   = prdata_q;
   assign pready   = pready_q;
   assign pslverr  = pslverr_q;
   assign mb_wr    = mb_wr_q;
   assign mb_rd    = mb_rd_q;
   assign mb_wdata = mb_wdata_q;

endmodule

// File: tb/tb_mailbox_apb_port.sv
// Self-checking bench for mailbox_apb_port: a transaction-level timing model fills
// per-cycle expectation tables that a single negedge process compares against the DUT.
module tb_mailbox_apb_port;

   localparam int         TIMEOUT = 15;
   localparam logic [7:0] SIDE_ID = 8'h0A;
   localparam int         NCYC    = 4096;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        psel      = 1'b0;
   logic        penable   = 1'b0;
   logic        pwrite    = 1'b0;
   logic [7:0]  paddr     = 8'd0;
   logic [31:0] pwdata    = 32'd0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        mb_wr;
   logic        mb_rd;
   logic [2:0]  mb_wdata;
   logic [2:0]  mb_rdata  = 3'd0;
   logic        mb_rvalid = 1'b0;
   logic        mp_irq    = 1'b0;

   int cyc        = 0;
   int compared   = 0;
   int mismatched = 0;
   bit checkEn    = 1'b0;

   bit          expWr   [NCYC];
   bit          expRd   [NCYC];
   bit          expRdy  [NCYC];
   bit          expErr  [NCYC];
   bit          expDatV [NCYC];
   logic [2:0]  expWd   [NCYC];
   logic [31:0] expDat  [NCYC];

   logic [15:0] mCnt     = 16'd0;
   logic        mPrev    = 1'b0;
   logic        mRise;
   logic        mSticky  = 1'b0;
   int          mClrCyc  = -1;
   int          mLoadCyc = -1;
   logic [15:0] mLoadVal = 16'd0;

   int          litPending = 0;
   int          litDone    = 0;
   string       litName;
   logic [31:0] litAct;
   logic [31:0] litExp;

   logic [31:0] gotData;
   logic        gotErr;
   int          lat;
   int          rc;

   mailbox_apb_port #(
      .ADDR_W (8),
      .TIMEOUT(TIMEOUT),
      .SIDE_ID(SIDE_ID)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr),
      .mb_wr    (mb_wr),
      .mb_rd    (mb_rd),
      .mb_wdata (mb_wdata),
      .mb_rdata (mb_rdata),
      .mb_rvalid(mb_rvalid),
      .mp_irq   (mp_irq)
   );

   always #5 clk = ~clk;

   // Interrupt-count model and cycle counter, advanced once per clock.
   always @(posedge clk) begin
      if (reset) begin
         mCnt  = 16'd0;
         mPrev = 1'b0;
      end else begin
         mRise = mp_irq && !mPrev;
         if (cyc == mLoadCyc) mCnt = mLoadVal;
         if (cyc == mClrCyc) mCnt = mRise ? 16'd1 : 16'd0;
         else if (mRise && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
         mPrev = mp_irq;
      end
      cyc = cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Single compare process: per-cycle table checks plus queued literal checks.
   always @(negedge clk) begin
      if (litPending != litDone) begin
         checkOutput(litName, litAct, litExp);
         litDone = litPending;
      end
      if (checkEn && !reset && cyc < NCYC) begin
         checkOutput("mb_wr", {31'd0, mb_wr}, {31'd0, expWr[cyc]});
         checkOutput("mb_rd", {31'd0, mb_rd}, {31'd0, expRd[cyc]});
         if (expWr[cyc]) checkOutput("mb_wdata", {29'd0, mb_wdata}, {29'd0, expWd[cyc]});
         checkOutput("pready", {31'd0, pready}, {31'd0, expRdy[cyc]});
         if (expRdy[cyc]) begin
            checkOutput("pslverr", {31'd0, pslverr}, {31'd0, expErr[cyc]});
            if (expDatV[cyc]) checkOutput("prdata", prdata, expDat[cyc]);
         end
      end
   end

   task automatic litCheck(input string name, input logic [31:0] act, input logic [31:0] exp);
      litName = name;
      litAct  = act;
      litExp  = exp;
      litPending++;
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   // One APB transfer starting with its setup phase in the current cycle.
   task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                                input int rvDelay, input logic [2:0] rdMb, input int abortAt,
                                output logic [31:0] dataOut, output logic errOut, output int latOut);
      int c, respCyc, rvCyc, endCyc;
      logic [31:0] eDat;
      bit eDatV, eErr;
      c = cyc; respCyc = c + 1; rvCyc = -1;
      eDat = 32'd0; eDatV = 1'b0; eErr = 1'b0;
      dataOut = 32'hDEAD_BEEF; errOut = 1'b0; latOut = -1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
      case (addr[3:2])
         2'd0: begin
            if (wr) begin
               expWr[c+1] = 1'b1;
               expWd[c+1] = wdata[2:0];
            end else begin
               expRd[c+1] = 1'b1;
               if (abortAt > 0) begin
                  respCyc = -1;
                  rvCyc   = c + abortAt + 1;
               end else if (rvDelay >= 0 && rvDelay <= TIMEOUT) begin
                  rvCyc   = c + 1 + rvDelay;
                  respCyc = rvCyc + 1;
                  eDat    = {29'd0, rdMb};
                  eDatV   = 1'b1;
               end else begin
                  respCyc = c + 1 + TIMEOUT + 1;
                  eErr    = 1'b1;
                  eDatV   = 1'b1;
                  mSticky = 1'b1;
               end
            end
         end
         2'd1: begin
            eDatV = 1'b1;
            if (wr) eErr = 1'b1;
            else    eDat = {16'd0, SIDE_ID, 6'd0, mSticky, mPrev};
         end
         2'd2: begin
            if (wr) mClrCyc = c;
            else begin
               eDatV = 1'b1;
               eDat  = {16'd0, mCnt};
            end
         end
         default: begin
            eErr  = 1'b1;
            eDatV = 1'b1;
         end
      endcase
      if (respCyc >= 0) begin
         expRdy[respCyc]  = 1'b1;
         expErr[respCyc]  = eErr;
         expDat[respCyc]  = eDat;
         expDatV[respCyc] = eDatV;
         endCyc = respCyc;
         latOut = respCyc - c;
      end else begin
         endCyc = rvCyc + 1;
      end
      @(posedge clk); #1;
      for (int k = c + 1; k <= endCyc; k++) begin
         if (k == c + 1) penable = 1'b1;
         if (abortAt > 0 && k == c + abortAt) begin
            psel    = 1'b0;
            penable = 1'b0;
         end
         mb_rvalid = (k == rvCyc);
         if (k == rvCyc) mb_rdata = rdMb;
         if (k == respCyc) begin
            @(negedge clk);
            dataOut = prdata;
            errOut  = pslverr;
         end
         @(posedge clk); #1;
      end
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; mb_rvalid = 1'b0;
   endtask

   task automatic pulseIrq();
      mp_irq = 1'b1;
      @(posedge clk); #1;
      mp_irq = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      litCheck("rst_prdata",   prdata,            32'd0);
      litCheck("rst_pready",   {31'd0, pready},   32'd0);
      litCheck("rst_pslverr",  {31'd0, pslverr},  32'd0);
      litCheck("rst_mb_wr",    {31'd0, mb_wr},    32'd0);
      litCheck("rst_mb_rd",    {31'd0, mb_rd},    32'd0);
      litCheck("rst_mb_wdata", {29'd0, mb_wdata}, 32'd0);
      reset   = 1'b0;
      checkEn = 1'b1;
      @(posedge clk); #1;

      $display("[TB] CTRL writes");
      applyStimulus(1'b1, 8'h00, 32'h0000_0007, 0, 3'd0, 0, gotData, gotErr, lat);
      litCheck("ctrl_wr_lat", 32'(lat), 32'd1);
      applyStimulus(1'b1, 8'h02, 32'hFFFF_FFF2, 0, 3'd0, 0, gotData, gotErr, lat);

      $display("[TB] CTRL reads");
      applyStimulus(1'b0, 8'h00, 32'd0, 1, 3'b101, 0, gotData, gotErr, lat);
      litCheck("ctrl_rd_data", gotData, 32'h0000_0005);
      litCheck("ctrl_rd_lat",  32'(lat), 32'd3);
      applyStimulus(1'b0, 8'h01, 32'd0, 4, 3'b010, 0, gotData, gotErr, lat);

      $display("[TB] CTRL read timeout");
      applyStimulus(1'b0, 8'h00, 32'd0, -1, 3'd0, 0, gotData, gotErr, lat);
      litCheck("to_err",  {31'd0, gotErr}, 32'd1);
      litCheck("to_data", gotData,         32'd0);
      litCheck("to_lat",  32'(lat),        32'd17);
      applyStimulus(1'b0, 8'h15, 32'd0, 0, 3'd0, 0, gotData, gotErr, lat);
      litCheck("status_after_to", gotData, 32'h0000_0A02);

      $display("[TB] IRQ counting");
      repeat (3) pulseIrq();
      applyStimulus(1'b0, 8'h4B, 32'd0, 0, 3'd0, 0, gotData, gotErr, lat);
      litCheck("irqcnt_3", gotData, 32'd3);
      mp_irq = 1'b1;
      applyStimulus(1'b1, 8'h08, 32'h1234_5678, 0, 3'd0, 0, gotData, gotErr, lat);
      mp_irq = 1'b0;
      @(posedge clk); #1;
      applyStimulus(1'b0, 8'h08, 32'd0, 0, 3'd0, 0, gotData, gotErr, lat);
      litCheck("irqcnt_clr_edge", gotData, 32'd1);

      $display("[TB] IRQ saturation");
      force dut.irqcnt_q = 16'hFFFE;
      mLoadVal = 16'hFFFE;
      mLoadCyc = cyc;
      @(posedge clk); #1;
      release dut.irqcnt_q;
      @(posedge clk); #1;
      pulseIrq();
      applyStimulus(1'b0, 8'h08, 32'd0, 0, 3'd0, 0, gotData, gotErr, lat);
      litCheck("irqcnt_max", gotData, 32'h0000_FFFF);
      pulseIrq();
      applyStimulus(1'b0, 8'h08, 32'd0, 0, 3'd0, 0, gotData, gotErr, lat);
      litCheck("irqcnt_sat", gotData, 32'h0000_FFFF);

      $display("[TB] error accesses");
      applyStimulus(1'b1, 8'h04, 32'hFFFF_FFFF, 0, 3'd0, 0, gotData, gotErr, lat);
      litCheck("status_wr_err", {31'd0, gotErr}, 32'd1);
      applyStimulus(1'b0, 8'h0C, 32'd0, 0, 3'd0, 0, gotData, gotErr, lat);
      litCheck("unmap_rd_err", {31'd0, gotErr}, 32'd1);
      applyStimulus(1'b1, 8'h0C, 32'h0000_0007, 0, 3'd0, 0, gotData, gotErr, lat);

      $display("[TB] master abort");
      applyStimulus(1'b0, 8'h00, 32'd0, 0, 3'b111, 2, gotData, gotErr, lat);
      applyStimulus(1'b0, 8'h04, 32'd0, 0, 3'd0, 0, gotData, gotErr, lat);
      applyStimulus(1'b0, 8'h00, 32'd0, 1, 3'b110, 0, gotData, gotErr, lat);
      litCheck("rd_after_abort", gotData, 32'h0000_0006);

      $display("[TB] reset during read");
      rc = cyc;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
      expRd[rc+1] = 1'b1;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      mSticky = 1'b0;
      litCheck("midrst_prdata", prdata,          32'd0);
      litCheck("midrst_pready", {31'd0, pready}, 32'd0);
      litCheck("midrst_mb_rd",  {31'd0, mb_rd},  32'd0);
      psel = 1'b0; penable = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      applyStimulus(1'b0, 8'h04, 32'd0, 0, 3'd0, 0, gotData, gotErr, lat);
      litCheck("status_after_rst", gotData, 32'h0000_0A00);
      applyStimulus(1'b0, 8'h00, 32'd0, 1, 3'b011, 0, gotData, gotErr, lat);
      litCheck("rd_after_rst", gotData, 32'h0000_0003);

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
